// File: rtl/product_accumulator_pkg.sv
// Shared definitions for the product accumulator: default widths, state
// encoding and the full-adder cell used by the accumulation adder.
package product_accumulator_pkg;

   localparam int DEF_PW = 8;
   localparam int DEF_LW = 4;
   localparam int DEF_SW = 12;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Returns {carry_out, sum} of a one-bit full adder.
   function automatic logic [1:0] full_add(input logic a, input logic b, input logic ci);
      return {(a & b) | (ci & (a ^ b)), a ^ b ^ ci};
   endfunction

endpackage

// File: rtl/acc_adder_12bit.sv
// Unsigned ripple-carry adder for the accumulator path; the final carry is
// dropped because the run length bounds the sum below 2^W.
module acc_adder_12bit
   import product_accumulator_pkg::*;
#(
   parameter int W = DEF_SW
) (
   input  logic [W-1:0] acc,
   input  logic [W-1:0] addend,
   output logic [W-1:0] next_acc
);

   logic [W-1:0] carry_s;

   assign carry_s[0] = 1'b0;

   for (genvar i = 0; i < W; i++) begin : g_bit
      if (i < W - 1) begin : g_fa
         logic [1:0] fa_s;
         assign fa_s          = full_add(acc[i], addend[i], carry_s[i]);
         assign next_acc[i]   = fa_s[0];
         assign carry_s[i+1]  = fa_s[1];
      end else begin : g_msb
         assign next_acc[i] = acc[i] ^ addend[i] ^ carry_s[i];
      end
   end

endmodule

// File: rtl/product_accumulator.sv
// Sequential dot-product stage: sums a run of 1..2^LW products taken over a
// valid/ready handshake and presents the held result on its own handshake.
module product_accumulator
   import product_accumulator_pkg::*;
#(
   parameter int PW = DEF_PW,
   parameter int LW = DEF_LW,
   parameter int SW = DEF_SW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [LW-1:0] len,
   input  logic [PW-1:0] p,
   input  logic          p_valid,
   output logic          p_ready,
   output logic [SW-1:0] sum,
   output logic          sum_valid,
   input  logic          sum_ready,
   output logic          busy
);

   state_t        state_r;
   logic [LW:0]   terms_r;
   logic [LW:0]   cnt_r;
   logic [LW:0]   cnt_inc_s;
   logic          last_beat_s;
   logic [SW-1:0] acc_r;
   logic [SW-1:0] next_acc_s;
   logic          p_ready_r;
   logic          sum_valid_r;
   logic          busy_r;

   acc_adder_12bit #(.W(SW)) u_adder (
      .acc      (acc_r),
      .addend   ({{(SW-PW){1'b0}}, p}),
      .next_acc (next_acc_s)
   );

   // Beat counter increment and detection of the run's final beat.
   always_comb begin
      cnt_inc_s   = cnt_r + {{LW{1'b0}}, 1'b1};
      last_beat_s = (cnt_inc_s == terms_r);
   end

   // Control FSM with accumulator, counters and registered handshake outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         terms_r     <= {(LW+1){1'b0}};
         cnt_r       <= {(LW+1){1'b0}};
         acc_r       <= {SW{1'b0}};
         p_ready_r   <= 1'b0;
         sum_valid_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  // A zero length encodes the full 2^LW-term run.
                  terms_r     <= (len == {LW{1'b0}}) ? {1'b1, {LW{1'b0}}} : {1'b0, len};
                  cnt_r       <= {(LW+1){1'b0}};
                  acc_r       <= {SW{1'b0}};
                  state_r     <= ST_ACC;
                  p_ready_r   <= 1'b1;
                  busy_r      <= 1'b1;
                  sum_valid_r <= 1'b0;
               end
            end
            ST_ACC: begin
               if (p_valid) begin
                  acc_r <= next_acc_s;
                  cnt_r <= cnt_inc_s;
                  if (last_beat_s) begin
                     state_r     <= ST_DONE;
                     p_ready_r   <= 1'b0;
                     sum_valid_r <= 1'b1;
                  end
               end
            end
            ST_DONE: begin
               if (sum_ready) begin
                  state_r     <= ST_IDLE;
                  sum_valid_r <= 1'b0;
                  busy_r      <= 1'b0;
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               p_ready_r   <= 1'b0;
               sum_valid_r <= 1'b0;
               busy_r      <= 1'b0;
            end
         endcase
      end
   end

   assign p_ready   = p_ready_r;
   assign sum_valid = sum_valid_r;
   assign busy      = busy_r;
   assign sum       = acc_r;

endmodule
